// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM time-slot arbiter: owner encoding and slot phase values.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_AUX  = 2'd3
  } owner_e;

  localparam logic SLOT_VID = 1'b1;
  localparam logic SLOT_CPU = 1'b0;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and RAM-side signal bundle of the VRAM arbiter.
// slave = arbiter view, master = requesters + RAM macro view.
interface vram_arb_if #(
  parameter int AW = 16,
  parameter int DW = 8
) ();

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;

  logic          cpu_en;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_ack;
  logic [DW-1:0] aux_rdata;
  logic          aux_rvalid;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr,
    output vid_rdata,
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_ack, aux_rdata, aux_rvalid,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_rdata,
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_ack, aux_rdata, aux_rvalid,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_arbiter_waitcnt.sv
// Saturating aux wait counter; at_limit flags that aux has waited LIMIT slots.
module vram_arb_waitcnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_en,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !wait_en) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/vram_arbiter.sv
// Time-slot arbiter for the shared video SPRAM (video / CPU / aux requesters).
// Define VRAM_ARB_STEAL_EN to let a starved aux requester steal CPU slots.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int STEAL_LIMIT = 15
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      cpu_clk,
  vram_arb_if.slave bus
);

  if (STEAL_LIMIT < 1 || STEAL_LIMIT > 255) begin : g_bad_limit
    $error("vram_arbiter: STEAL_LIMIT must be within 1..255");
  end

  owner_e        owner_q;
  owner_e        win;
  logic          aux_ack_q;
  logic          aux_ok;
  logic          at_limit;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] aux_rdata_q;
  logic          aux_rvalid_q;

  // An aux request acked on the previous edge may still be the stale one.
  assign aux_ok = bus.aux_req && !aux_ack_q;

  always_comb begin
    win = OWN_NONE;
    if (cpu_clk == SLOT_VID) begin
      if (bus.vid_req)  win = OWN_VID;
      else if (aux_ok)  win = OWN_AUX;
    end else begin
      if (aux_ok && at_limit) win = OWN_AUX;
      else if (bus.cpu_en)    win = OWN_CPU;
      else if (aux_ok)        win = OWN_AUX;
    end
  end

`ifdef VRAM_ARB_STEAL_EN
  logic stall_q;

  vram_arb_waitcnt #(.LIMIT(STEAL_LIMIT)) u_waitcnt (
    .clk      (clk),
    .rst      (rst),
    .wait_en  (bus.aux_req && (win != OWN_AUX)),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) stall_q <= 1'b0;
    else     stall_q <= (cpu_clk == SLOT_CPU) && aux_ok && at_limit;
  end

  assign bus.cpu_stall = stall_q;
`else
  assign at_limit      = 1'b0;
  assign bus.cpu_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      aux_ack_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      aux_rdata_q  <= '0;
      aux_rvalid_q <= 1'b0;
    end else begin
      owner_q   <= win;
      aux_ack_q <= (win == OWN_AUX);
      case (win)
        OWN_VID: begin
          mem_addr_q <= bus.vid_addr;
          mem_we_q   <= 1'b0;
        end
        OWN_CPU: begin
          mem_addr_q  <= bus.cpu_addr;
          mem_we_q    <= bus.cpu_we;
          mem_wdata_q <= bus.cpu_wdata;
        end
        OWN_AUX: begin
          mem_addr_q  <= bus.aux_addr;
          mem_we_q    <= bus.aux_we;
          mem_wdata_q <= bus.aux_wdata;
        end
        default: mem_we_q <= 1'b0;
      endcase
      // RAM data for the access issued on the previous edge arrives now.
      if (owner_q == OWN_CPU && !mem_we_q) cpu_rdata_q <= bus.mem_rdata;
      if (owner_q == OWN_AUX && !mem_we_q) aux_rdata_q <= bus.mem_rdata;
      aux_rvalid_q <= (owner_q == OWN_AUX) && !mem_we_q;
    end
  end

  assign bus.vid_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.aux_rdata  = aux_rdata_q;
  assign bus.aux_rvalid = aux_rvalid_q;
  assign bus.aux_ack    = aux_ack_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, starvation traffic, randomized
// traffic against a slot-rule reference model, and reset during a pending read.
module tb_vram_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int LIMIT = 15;
`ifdef VRAM_ARB_STEAL_EN
  localparam bit STEAL_ON = 1'b1;
`else
  localparam bit STEAL_ON = 1'b0;
`endif

  localparam int O_NONE = 0, O_VID = 1, O_CPU = 2, O_AUX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_clk = 1'b1;
  logic ram_clr = 1'b1;

  vram_arb_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW), .STEAL_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_clk (cpu_clk),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // RAM macro: combinational read, write on the edge after issue.
  logic [7:0] ram [0:255];
  function automatic logic [7:0] hidx(input logic [15:0] a);
    return {a[15:12], a[3:0]};
  endfunction
  assign bus.mem_rdata = ram[hidx(bus.mem_addr)];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (bus.mem_we) begin
      ram[hidx(bus.mem_addr)] <= bus.mem_wdata;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_prev_owner;
  bit          m_prev_we;
  bit          m_acked;
  int          m_waited;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  e_cpu_rd, e_aux_rd;
  bit          e_rvalid, e_stall, e_ack, e_we;
  int          m_acks;
  logic [7:0]  shadow [int];

  function automatic logic [7:0] shadow_rd(input logic [15:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : 8'h00;
  endfunction

  task automatic model_reset();
    m_prev_owner = O_NONE; m_prev_we = 1'b0; m_acked = 1'b0; m_waited = 0;
    m_addr = '0; m_wdata = '0; e_cpu_rd = '0; e_aux_rd = '0;
  endtask

  task automatic model_edge();
    int  own;
    bit  aux_ok;
    e_rvalid = 1'b0;
    e_stall  = 1'b0;
    if (m_prev_owner == O_CPU && !m_prev_we) e_cpu_rd = shadow_rd(m_addr);
    if (m_prev_owner == O_AUX && !m_prev_we) begin
      e_aux_rd = shadow_rd(m_addr);
      e_rvalid = 1'b1;
    end
    aux_ok = bus.aux_req && !m_acked;
    own = O_NONE;
    if (cpu_clk) begin
      if (bus.vid_req) own = O_VID;
      else if (aux_ok) own = O_AUX;
    end else begin
      if (STEAL_ON && aux_ok && m_waited >= LIMIT) begin
        own = O_AUX;
        e_stall = 1'b1;
      end else if (bus.cpu_en) own = O_CPU;
      else if (aux_ok) own = O_AUX;
    end
    e_we = 1'b0;
    if (own == O_VID) m_addr = bus.vid_addr;
    if (own == O_CPU) begin m_addr = bus.cpu_addr; e_we = bus.cpu_we; m_wdata = bus.cpu_wdata; end
    if (own == O_AUX) begin m_addr = bus.aux_addr; e_we = bus.aux_we; m_wdata = bus.aux_wdata; end
    if (e_we) shadow[int'(m_addr)] = m_wdata;
    m_waited = (bus.aux_req && own != O_AUX) ? m_waited + 1 : 0;
    e_ack = (own == O_AUX);
    if (e_ack) m_acks++;
    m_acked = e_ack;
    m_prev_owner = own;
    m_prev_we = e_we;
  endtask

  task automatic mstep();
    model_edge();
    @(posedge clk); #1;
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, m_addr);
    if (e_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("aux_ack", bus.aux_ack, e_ack);
    chk("cpu_stall", bus.cpu_stall, e_stall);
    chk("aux_rvalid", bus.aux_rvalid, e_rvalid);
    if (e_rvalid) chk("aux_rdata", bus.aux_rdata, e_aux_rd);
    chk("cpu_rdata", bus.cpu_rdata, e_cpu_rd);
    cpu_clk = ~cpu_clk;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 16'h0);
      chk("rst_aux_ack", bus.aux_ack, 1'b0);
      chk("rst_cpu_stall", bus.cpu_stall, 1'b0);
      chk("rst_aux_rvalid", bus.aux_rvalid, 1'b0);
      cpu_clk = ~cpu_clk;
    end
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        slot;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        cpu_en;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        aux_req;
    logic        aux_we;
    logic [15:0] aux_addr;
    logic [7:0]  aux_wdata;
    logic [15:0] e_addr;
    logic        e_we;
    logic        e_ack;
    logic        e_rvalid;
    logic [7:0]  e_aux_rd;
    logic [7:0]  e_cpu_rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n_ack, n_stall, n_ack_nostall, acks0;
    bit pend;

    bus.vid_req = 1'b1; bus.vid_addr = 16'hFFFF;
    bus.cpu_en = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'hEEEE; bus.cpu_wdata = 8'h11;
    bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 16'hDDDD; bus.aux_wdata = 8'h22;
    m_acks = 0;

    // Reset with every requester active: nothing may be issued.
    do_reset(3);
    ram_clr = 1'b0;

    //         slot  vreq  vaddr      cen   cwe   caddr      cwd     areq  awe   aaddr      awd     e_addr     e_we  e_ack e_rv  e_ard   e_crd
    tbl[0]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0BEE, 8'h00, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2000, 8'h5A, 1'b1, 1'b0, 16'h0BEE, 8'h00, 16'h2000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h2000, 8'h00, 16'h2000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h2000, 8'h00, 16'h2000, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h3000, 8'hC3, 16'h3000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h3000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h3000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h2000, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3};
    tbl[8]  = '{1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h4000, 8'hFF, 16'h0020, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h3000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h3000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h3000, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h4000, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3};
    tbl[12] = '{1'b1, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0030, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

    for (int i = 0; i < 13; i++) begin
      cpu_clk = tbl[i].slot;
      bus.vid_req = tbl[i].vid_req;   bus.vid_addr = tbl[i].vid_addr;
      bus.cpu_en = tbl[i].cpu_en;     bus.cpu_we = tbl[i].cpu_we;
      bus.cpu_addr = tbl[i].cpu_addr; bus.cpu_wdata = tbl[i].cpu_wdata;
      bus.aux_req = tbl[i].aux_req;   bus.aux_we = tbl[i].aux_we;
      bus.aux_addr = tbl[i].aux_addr; bus.aux_wdata = tbl[i].aux_wdata;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_mem_we", i), bus.mem_we, tbl[i].e_we);
      chk($sformatf("vec%0d_aux_ack", i), bus.aux_ack, tbl[i].e_ack);
      chk($sformatf("vec%0d_aux_rvalid", i), bus.aux_rvalid, tbl[i].e_rvalid);
      if (tbl[i].e_rvalid) chk($sformatf("vec%0d_aux_rdata", i), bus.aux_rdata, tbl[i].e_aux_rd);
      chk($sformatf("vec%0d_cpu_rdata", i), bus.cpu_rdata, tbl[i].e_cpu_rd);
      chk($sformatf("vec%0d_cpu_stall", i), bus.cpu_stall, 1'b0);
      chk($sformatf("vec%0d_vid_rdata", i), bus.vid_rdata, bus.mem_rdata);
    end

    // Saturated traffic: video and CPU use every slot, aux always asking.
    bus.aux_req = 1'b0;
    do_reset(2);
    cpu_clk = 1'b1;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0100;
    bus.cpu_en = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8001;
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 16'h8005;
    n_ack = 0; n_stall = 0; n_ack_nostall = 0; acks0 = m_acks;
    for (int i = 0; i < 100; i++) begin
      mstep();
      if (bus.aux_ack) n_ack++;
      if (bus.cpu_stall) n_stall++;
      if (bus.aux_ack != bus.cpu_stall) n_ack_nostall++;
    end
    if (STEAL_ON) begin
      chk("steal_ack_count", n_ack, m_acks - acks0);
      chk("steal_ack_is_stall", n_ack_nostall, 0);
    end else begin
      chk("prio_ack_count", n_ack, 0);
      chk("prio_stall_count", n_stall, 0);
    end

    // Randomized traffic against the model.
    bus.aux_req = 1'b0;
    do_reset(2);
    cpu_clk = 1'b1;
    pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.vid_req = ($urandom_range(0, 9) < 6);
      bus.vid_addr = 16'($urandom);
      bus.cpu_en = $urandom_range(0, 1) == 1;
      bus.cpu_we = $urandom_range(0, 1) == 1;
      bus.cpu_addr = 16'h8000 + 16'($urandom_range(0, 15));
      bus.cpu_wdata = 8'($urandom);
      if (pend && bus.aux_ack) pend = 1'b0;
      if (!pend) begin
        if ($urandom_range(0, 1) == 1) begin
          pend = 1'b1;
          bus.aux_req = 1'b1;
          bus.aux_we = $urandom_range(0, 1) == 1;
          bus.aux_addr = 16'h8000 + 16'($urandom_range(0, 15));
          bus.aux_wdata = 8'($urandom);
        end else begin
          bus.aux_req = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 3) begin
        pend = 1'b0;
        bus.aux_req = 1'b0;
      end
      mstep();
    end

    // Reset while an aux read is in flight: its data must never be reported.
    bus.vid_req = 1'b0; bus.cpu_en = 1'b0; bus.aux_req = 1'b0;
    cpu_clk = 1'b1;
    mstep();
    cpu_clk = 1'b1;
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 16'h8003;
    mstep();
    chk("midrst_grant", bus.aux_ack, 1'b1);
    bus.aux_req = 1'b0;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_rvalid", bus.aux_rvalid, 1'b0);
      chk("midrst_ack", bus.aux_ack, 1'b0);
      cpu_clk = ~cpu_clk;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Time-slot arbiter for the single-port video RAM (SPRAM) shared by three requesters: the VGA fetch engine, the 6502 CPU, and an auxiliary requester (blitter or SPI loader).
- Slots alternate with the CPU clock phase. cpu_clk=1 is the video slot; cpu_clk=0 is the CPU slot.
- The aux requester uses slots the owner leaves idle. With an optional feature it can also steal CPU slots after waiting too long.
- The block sits between the VGA/CPU/aux address paths and the RAM macro.

Parameters:
- AW, 16: RAM address width.
- DW, 8: RAM data width.
- STEAL_LIMIT, 15: idle-wait slot count before aux steals a CPU slot; valid range 1–255.

Ports:
- clk  in  1  pixel clock, 25.175MHz.
- rst  in  1  synchronous reset, active-high.
- cpu_clk  in  1  slot phase. 1 = video slot, 0 = CPU slot. Toggles every clk.
- vid_req  in  1  VGA wants the current video slot.
- vid_addr  in  AW  VGA read address.
- vid_rdata  out  DW  RAM read data for VGA. Combinational copy of mem_rdata.
- cpu_en  in  1  CPU accesses VRAM this slot.
- cpu_we  in  1  CPU write.
- cpu_addr  in  AW  CPU address, already paged.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  registered CPU read data.
- cpu_stall  out  1  CPU slot was stolen; CPU must repeat the access.
- aux_req  in  1  aux request. Hold with stable addr/we/wdata until aux_ack.
- aux_we  in  1  aux write.
- aux_addr  in  AW  aux address.
- aux_wdata  in  DW  aux write data.
- aux_ack  out  1  one-clk pulse: access issued this cycle.
- aux_rdata  out  DW  aux read data.
- aux_rvalid  out  1  one-clk pulse: aux_rdata valid.
- mem_addr  out  AW  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  DW  RAM write data, registered.
- mem_rdata  in  DW  RAM read data, valid one clk after issue.

Behaviour:
- Reset: all registered outputs and internal state go to 0. Owner register = OWN_NONE. Wait counter = 0. Any pending aux request is forgotten; the requester keeps aux_req high and is served later under normal rules.
- Each posedge clk (not in reset), the winner is chosen from cpu_clk sampled at that edge. The winner's addr/we/wdata are latched into the mem_* registers; owner register = winner.
- Video slot (cpu_clk=1):
  - vid_req → OWN_VID, mem_we=0.
  - else aux_req and not acked the previous clk → OWN_AUX.
  - else OWN_NONE with mem_we=0; mem_addr holds its value.
- CPU slot (cpu_clk=0):
  - Steal condition (STEAL_EN only): aux_req and wait counter = STEAL_LIMIT → OWN_AUX, cpu_stall=1.
  - else cpu_en → OWN_CPU.
  - else aux_req → OWN_AUX.
  - else OWN_NONE.
- cpu_stall is high only for the clk following the stolen-slot edge. Otherwise it is 0.
- aux_ack is registered and high in the same clk that mem_* carries the aux access. The requester may change or drop aux_req after seeing aux_ack.
  - The arbiter blocks re-grant on the next edge so a stale req is not issued twice.
- If aux_req drops before ack, nothing is issued and no ack is given.
- Read return, one clk after issue, based on the previous owner:
  - OWN_CPU read → cpu_rdata <= mem_rdata.
  - OWN_AUX read → aux_rdata <= mem_rdata and aux_rvalid=1 for one clk.
  - Writes produce no rvalid. cpu_rdata/aux_rdata hold their value otherwise.
- Wait counter:
  - +1 per clk edge while aux_req is high and aux is not granted; saturates at STEAL_LIMIT.
  - Cleared on aux grant or when aux_req is low.
  - Width is $clog2(STEAL_LIMIT+1).
- Video always wins its own slot. VGA timing is never disturbed by aux.
- Throughput bound: at most one aux access per 2 clks.

Optional Feature:
- Macro: VRAM_ARB_STEAL_EN.
- Defined: the starvation steal rule above is active, and cpu_stall can assert.
- Undefined:
  - aux uses only idle slots;
  - cpu_stall is tied to 0;
  - the wait counter is omitted;
  - STEAL_LIMIT is ignored.

Decomposition:
- Package vram_arb_pkg:
  - owner encoding: OWN_NONE=2'd0, OWN_VID=2'd1, OWN_CPU=2'd2, OWN_AUX=2'd3;
  - SLOT_VID=1'b1, SLOT_CPU=1'b0.
- One sub-module, vram_arb_waitcnt: saturating wait counter with limit-reached flag. Instantiated only under VRAM_ARB_STEAL_EN.

Test Plan:
- Reset: hold rst 3 clks with all reqs high → mem_we=0, mem_addr=0, aux_ack=0, cpu_stall=0; the first grant follows the first post-reset edge.
- Video slot: vid_req=1, vid_addr=0x1234, aux_req=1 → mem_addr=0x1234 on the video edge and aux not acked. Next, vid_req=0 on the video edge → aux granted, aux_ack=1, mem_addr=aux_addr.
- CPU write, then aux read of the same address:
  - CPU writes 0x5A at 0x2000; aux_req reads 0x2000 and takes the idle video slot;
  - → aux_rvalid one clk later with aux_rdata=0x5A (RAM model).
- CPU priority: cpu_en=1 every CPU slot, vid_req=1 every video slot, aux_req=1, STEAL_EN off → aux_ack never asserts over 100 clks and cpu_stall stays 0.
- Steal with STEAL_EN and STEAL_LIMIT=15: same traffic as the previous scenario → first aux_ack on a CPU slot once the counter saturates; cpu_stall=1 for that one clk; counter resets; the pattern repeats.
- Aux drop and mid-reset:
  - aux_req pulses one clk with no free slot → no ack, no mem_we.
  - Assert rst during a pending aux read → no aux_rvalid after reset deasserts.
